// File: rtl/gf4_mul_2om_compress.sv
// Share compression for a 3-share GF(2^2) multiplier: registers the nine
// cross-share component outputs, then folds them into three output shares.
module gf4_mul_2om_compress #(
    parameter int unsigned OUT_REG = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] cf0,
    input  logic [8:0] cf1,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] z1,
    output logic [1:0] z2,
    output logic [1:0] z3
);

    localparam int unsigned NSHARE = 3;
    localparam int unsigned CFW    = NSHARE * NSHARE;
    localparam int unsigned ZW     = 2 * NSHARE;

    logic           a_valid_q;
    logic           a_valid_d;
    logic [CFW-1:0] a_cf0_q;
    logic [CFW-1:0] a_cf0_d;
    logic [CFW-1:0] a_cf1_q;
    logic [CFW-1:0] a_cf1_d;
    logic           in_fire;
    logic           a_advance;
    logic           stage_b_free;
    logic [ZW-1:0]  a_z;

    assign a_advance = a_valid_q && stage_b_free;
    assign in_ready  = !a_valid_q || a_advance;
    assign in_fire   = in_valid && in_ready;

    // Stage A: glitch barrier; data flops load only on an accepted set
    always_comb begin
        a_valid_d = a_valid_q;
        a_cf0_d   = a_cf0_q;
        a_cf1_d   = a_cf1_q;
        if (a_advance) begin
            a_valid_d = 1'b0;
        end
        if (in_fire) begin
            a_valid_d = 1'b1;
            a_cf0_d   = cf0;
            a_cf1_d   = cf1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q <= 1'b0;
            a_cf0_q   <= '0;
            a_cf1_q   <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            a_cf0_q   <= a_cf0_d;
            a_cf1_q   <= a_cf1_d;
        end
    end

    // Share k folds the three instances that share y-index k
    always_comb begin
        a_z = '0;
        for (int k = 0; k < NSHARE; k++) begin
            a_z[2*k]   = ^a_cf0_q[3*k +: 3];
            a_z[2*k+1] = ^a_cf1_q[3*k +: 3];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic          b_valid_q;
            logic          b_valid_d;
            logic [ZW-1:0] b_z_q;
            logic [ZW-1:0] b_z_d;

            assign stage_b_free = !b_valid_q || out_ready;

            always_comb begin
                b_valid_d = b_valid_q;
                b_z_d     = b_z_q;
                if (out_ready) begin
                    b_valid_d = 1'b0;
                end
                if (a_advance) begin
                    b_valid_d = 1'b1;
                    b_z_d     = a_z;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_valid_q <= 1'b0;
                    b_z_q     <= '0;
                end else begin
                    b_valid_q <= b_valid_d;
                    b_z_q     <= b_z_d;
                end
            end

            assign out_valid    = b_valid_q;
            assign {z3, z2, z1} = b_z_q;
        end else begin : g_out_comb
            assign stage_b_free = out_ready;
            assign out_valid    = a_valid_q;
            assign {z3, z2, z1} = a_z;
        end
    endgenerate

endmodule

// File: tb/tb_gf4_mul_2om_compress.sv
// Self-checking bench for gf4_mul_2om_compress (registered and combinational
// output builds) against a queue-based reference of accepted sets.
module tb_gf4_mul_2om_compress;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [8:0] cf0, cf1;
    logic [1:0] z1, z2, z3;

    logic       in_valid0, in_ready0, out_valid0, out_ready0;
    logic [8:0] cf0_0, cf1_0;
    logic [1:0] y1, y2, y3;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;

    logic [5:0] exp_q[$];
    logic       pend_push, pend_pop, last_stall;
    logic [5:0] pend_val;
    logic [6:0] last_val;

    logic [8:0] s0[3];
    logic [8:0] s1[3];
    logic [1:0] xs[3];
    logic [1:0] ys[3];

    always #5 clk = ~clk;

    gf4_mul_2om_compress #(.OUT_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .cf0(cf0), .cf1(cf1),
        .out_valid(out_valid), .out_ready(out_ready),
        .z1(z1), .z2(z2), .z3(z3)
    );

    gf4_mul_2om_compress #(.OUT_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .cf0(cf0_0), .cf1(cf1_0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .z1(y1), .z2(y2), .z3(y3)
    );

    // Reference: share k bit b is the parity of the three cf_b bits with y-index k
    function automatic logic [5:0] ref_z(input logic [8:0] a, input logic [8:0] b);
        logic [5:0] r;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                r[2*k]   = r[2*k] ^ a[3*k+j];
                r[2*k+1] = r[2*k+1] ^ b[3*k+j];
            end
        end
        return r;
    endfunction

    // Polynomial-basis GF(4) product, used to build the component outputs
    function automatic logic [1:0] gf_mul_poly(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] p;
        p = '0;
        if (b[0]) p = p ^ {1'b0, a};
        if (b[1]) p = p ^ {a, 1'b0};
        if (p[2]) p = p ^ 3'b111;
        return p[1:0];
    endfunction

    // Independent log/antilog GF(4) product for the unmasked reference
    function automatic logic [1:0] gf_mul_log(input logic [1:0] a, input logic [1:0] b);
        int la, lb;
        if (a == 2'd0 || b == 2'd0) return 2'd0;
        la = (a == 2'd1) ? 0 : (a == 2'd2) ? 1 : 2;
        lb = (b == 2'd1) ? 0 : (b == 2'd2) ? 1 : 2;
        case ((la + lb) % 3)
            0:       return 2'd1;
            1:       return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Settle after driving, compare against the scoreboard, note pending fires
    task automatic sample();
        #1;
        if (last_stall) check("stall_hold", 32'({out_valid, z3, z2, z1}), 32'(last_val));
        check("no_spurious_out", 32'(out_valid && exp_q.size() == 0), 32'(0));
        if (out_valid && exp_q.size() != 0) check("z_vs_model", 32'({z3, z2, z1}), 32'(exp_q[0]));
        pend_pop   = out_valid && out_ready && exp_q.size() != 0;
        pend_push  = in_valid && in_ready;
        pend_val   = ref_z(cf0, cf1);
        if (out_valid && out_ready) n_out++;
        last_stall = out_valid && !out_ready;
        last_val   = {out_valid, z3, z2, z1};
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (pend_pop) exp_q.delete(0);
        if (pend_push) exp_q.push_back(pend_val);
        pend_pop  = 1'b0;
        pend_push = 1'b0;
    endtask

    initial begin
        int idx;
        int out_base;
        logic [8:0] a0, a1;
        logic [1:0] x, y, pr;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cf0 = '0; cf1 = '0;
        in_valid0 = 1'b0; out_ready0 = 1'b1; cf0_0 = '0; cf1_0 = '0;
        pend_push = 1'b0; pend_pop = 1'b0; last_stall = 1'b0; pend_val = '0; last_val = '0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_z", 32'({z3, z2, z1}), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst0_out_valid", 32'(out_valid0), 32'(0));
        check("rst0_z", 32'({y3, y2, y1}), 32'(0));
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed set on both builds
        in_valid = 1'b1; cf0 = 9'b000000111; cf1 = 9'b111000001; out_ready = 1'b1;
        in_valid0 = 1'b1; cf0_0 = 9'b000000111; cf1_0 = 9'b111000001;
        sample();
        check("dir_in_ready", 32'(in_ready), 32'(1));
        check("dir0_in_ready", 32'(in_ready0), 32'(1));
        advance();
        in_valid = 1'b0; in_valid0 = 1'b0;
        sample();
        check("dir_lat1_out_valid", 32'(out_valid), 32'(0));
        check("dir0_lat1_out_valid", 32'(out_valid0), 32'(1));
        check("dir0_z", 32'({y3, y2, y1}), 32'(6'b10_00_11));
        advance();
        sample();
        check("dir_lat2_out_valid", 32'(out_valid), 32'(1));
        check("dir_z", 32'({z3, z2, z1}), 32'(6'b10_00_11));
        check("dir0_single_out", 32'(out_valid0), 32'(0));
        advance();
        sample();
        check("dir_single_out", 32'(out_valid), 32'(0));
        advance();

        // Back-to-back random sets at full throughput
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 8);
            cf0 = 9'($urandom); cf1 = 9'($urandom);
            sample();
            check("b2b_in_ready", 32'(in_ready), 32'(1));
            check("b2b_out_valid", 32'(out_valid), 32'(i >= 2));
            advance();
        end
        in_valid = 1'b0;
        sample(); advance();

        // Backpressure: three sets offered while the consumer stalls
        for (int i = 0; i < 3; i++) begin
            s0[i] = 9'($urandom); s1[i] = 9'($urandom);
        end
        out_ready = 1'b0; idx = 0; out_base = n_out;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; cf0 = s0[idx]; cf1 = s1[idx];
            sample();
            check("bp_in_ready", 32'(in_ready), 32'(c < 2));
            if (in_valid && in_ready) idx++;
            advance();
        end
        check("bp_accepted", 32'(idx), 32'(2));
        out_ready = 1'b1; cf0 = s0[2]; cf1 = s1[2];
        sample();
        check("bp_release_in_ready", 32'(in_ready), 32'(1));
        check("bp_release_first", 32'({z3, z2, z1}), 32'(ref_z(s0[0], s1[0])));
        advance();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            sample(); advance();
        end
        check("bp_delivered", 32'(n_out - out_base), 32'(3));
        check("bp_drained", 32'(exp_q.size()), 32'(0));

        // Asynchronous reset with both stages full
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cf0 = 9'($urandom); cf1 = 9'($urandom);
            sample(); advance();
        end
        sample();
        check("full_in_ready", 32'(in_ready), 32'(0));
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'(0));
        check("arst_z", 32'({z3, z2, z1}), 32'(0));
        check("arst_in_ready", 32'(in_ready), 32'(1));
        exp_q.delete(); pend_push = 1'b0; pend_pop = 1'b0; last_stall = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sample();
            check("post_rst_idle", 32'(out_valid), 32'(0));
            advance();
        end

        // Masked GF(4) multiplication, all 16 operand pairs
        for (int xi = 0; xi < 4; xi++) begin
            for (int yi = 0; yi < 4; yi++) begin
                x = 2'(xi); y = 2'(yi);
                xs[0] = 2'($urandom); xs[1] = 2'($urandom); xs[2] = x ^ xs[0] ^ xs[1];
                ys[0] = 2'($urandom); ys[1] = 2'($urandom); ys[2] = y ^ ys[0] ^ ys[1];
                a0 = '0; a1 = '0;
                for (int j = 0; j < 3; j++) begin
                    for (int i = 0; i < 3; i++) begin
                        pr = gf_mul_poly(xs[i], ys[j]);
                        a0[3*j+i] = pr[0];
                        a1[3*j+i] = pr[1];
                    end
                end
                in_valid = 1'b1; cf0 = a0; cf1 = a1;
                sample(); advance();
                in_valid = 1'b0;
                sample(); advance();
                sample();
                check("mask_out_valid", 32'(out_valid), 32'(1));
                check("mask_product", 32'(z1 ^ z2 ^ z3), 32'(gf_mul_log(x, y)));
                advance();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
